sea_iter_core: RTL
==================

// Module: sea_iter_core
// PURPOSE
//  Iterative, parametrised SEA(n,b) cipher core: one round per clock, encrypt or decrypt per
//  transaction. Ready/valid on both sides. Replaces the fixed 48-bit unrolled enc/dec pair with
//  one engine that also returns the final key state.
// PARAMETERS
//  N   96  block width in bits; halves are N/2. N % (6*B) == 0, so NB = N/(2B) is a multiple of 3.
//  B   8   word width in bits.
//  NR  92  round count, >= 1. Default is 3N/4 + 2*(NB + B/2).
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    async active-low reset
//  in_valid   in   1    request valid
//  in_ready   out  1    core idle, request accepted when in_valid && in_ready
//  in_mode    in   1    0 = encrypt, 1 = decrypt
//  in_l/in_r  in   N/2  data halves; decrypt: (L_NR, R_NR)
//  in_kl/kr   in   N/2  key halves; encrypt: (KL_0, KR_0); decrypt: final key (KL_NR, KR_NR)
//  out_valid  out  1    result valid
//  out_ready  in   1    consumer accepts result
//  out_l/r    out  N/2  result data halves
//  out_kl/kr  out  N/2  encrypt: (KL_NR, KR_NR); decrypt: recovered (KL_0, KR_0)
//  busy       out  1    high in RUN or DONE
// BEHAVIOUR
//  Word ops on an N/2 half. Word 0 = bits [B-1:0].
//  - x+k: word-wise add mod 2^B, carries never cross words.
//  - S: for each group g, take word bit j of words 3g, 3g+1, 3g+2 as a 3-bit value
//    (word 3g = LSB). Map through SBOX = {0,5,6,7,4,3,1,2}; write back bit-sliced.
//  - r: word 3g rotated right 1 bit, word 3g+1 unchanged, word 3g+2 rotated left 1 bit.
//  - R: output word (i+1)%NB = input word i; R^-1 is the inverse.
//  - C(i): word 0 = i mod 2^B, all other words 0.
//  Encrypt round i (i = 0..NR-1), data and key updated in the same cycle:
//    L' = R;  R' = R(L) ^ r(S(R + KR_i))
//    KL' = KR_i;  KR' = KL_i ^ R(r(S(KR_i + C(i))))
//  Decrypt step j (j = NR-1 down to 0). Recover the key first, combinationally, then the data:
//    KR_j = KL_j+1;  KL_j = KR_j+1 ^ R(r(S(KL_j+1 + C(j))))
//    R_j = L_j+1;  L_j = R^-1(R_j+1 ^ r(S(L_j+1 + KR_j)))
//  Invariant: decrypt(encrypt(P, K)) returns P and K.
//  FSM
//    IDLE: in_ready = 1.
//          On accept: latch the operands and mode; load round counter (0 for enc, NR-1 for dec); -> RUN.
//    RUN:  one round per cycle. Counter counts up (enc) or down (dec).
//          -> DONE after the NR-th round.
//    DONE: out_valid = 1, outputs stable. On out_ready -> IDLE.
//  Timing and handshake
//    - Latency: accept edge plus NR clocks to out_valid; minimum initiation interval NR + 2.
//    - in_ready is 0 in RUN and DONE. No overlap with a pending result; in_valid is ignored there.
//    - out_valid stays high with stable data until out_ready; it is never withdrawn.
//    - Input operands may change after the accept edge without effect.
//  Reset (async assert, sync deassert by system)
//    - Values: state = IDLE, counter = 0, all data/key registers = 0, out_valid = 0, busy = 0,
//      in_ready = 1 on the first clock after release.
//    - Mid-RUN or mid-DONE reset aborts the transaction; no partial result is ever flagged valid.
//  Width and boundary rules
//    - Counter width clog2(NR); C(i) truncates i to B bits.
//    - NR = 1 is legal: exactly one round, and out_valid on the 2nd edge after accept.
//    - out_ready held high in IDLE/RUN has no effect.
// STRUCTURE
//  sea_defs.vh (shared include):
//    - SBOX table
//    - functions sea_add, sea_sbox, sea_rotbits, sea_rotw, sea_rotw_inv, sea_const, parameterised on B/NB.
//  Sub-module sea_round:
//    - combinational, parameter N/B.
//    - inputs mode, l, r, kl, kr, idx; outputs l_n, r_n, kl_n, kr_n.
//  This core holds FSM, counter, and registers only.
// TESTING
//  1 Reset: assert rst_n=0 mid-RUN -> out_valid=0, busy=0, outputs 0; in_ready=1 after release.
//  2 NR=2, N=96, B=8, encrypt all-zero data/key -> out_l=out_r=0, out_kl=0,
//    out_kr=48'h000002008000, out_valid on 3rd edge after accept.
//  3 Random P,K at defaults: encrypt, then decrypt with (out_l,out_r,out_kl,out_kr)
//    -> returns P and K; 1000 vectors.
//  4 Backpressure: out_ready=0 for 50 cycles after out_valid -> outputs stable, in_ready=0,
//    a new in_valid is not accepted; out_ready=1 -> IDLE next edge.
//  5 Back-to-back: in_valid held high across two requests -> accepts exactly NR+2 cycles apart.
//  6 Param sweep N=48/B=8, N=144/B=8, NR=1 -> round trip holds; latency = NR+1 edges.

Source files
------------

// File: rtl/sea_iter_core_pkg.sv
// Shared types and S-box for the iterative SEA core.
// Imported by the round datapath and the control core.
package sea_iter_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ENC = 1'b0;

    function automatic logic [2:0] sea_sbox3(input logic [2:0] x);
        logic [2:0] y;
        unique case (x)
            3'd0:    y = 3'd0;
            3'd1:    y = 3'd5;
            3'd2:    y = 3'd6;
            3'd3:    y = 3'd7;
            3'd4:    y = 3'd4;
            3'd5:    y = 3'd3;
            3'd6:    y = 3'd1;
            default: y = 3'd2;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/sea_iter_core_round.sv
// One SEA round, combinational; encrypt forward or
// decrypt backward (key recovered before the data).
module sea_round
    import sea_iter_core_pkg::*;
#(
    parameter int N  = 96,
    parameter int B  = 8,
    parameter int CW = 7
) (
    input  logic           mode,
    input  logic [N/2-1:0] l,
    input  logic [N/2-1:0] r,
    input  logic [N/2-1:0] kl,
    input  logic [N/2-1:0] kr,
    input  logic [CW-1:0]  idx,
    output logic [N/2-1:0] l_n,
    output logic [N/2-1:0] r_n,
    output logic [N/2-1:0] kl_n,
    output logic [N/2-1:0] kr_n
);
    localparam int H  = N / 2;
    localparam int NB = H / B;
    localparam int NG = NB / 3;

    typedef logic [H-1:0] half_t;

    function automatic half_t sea_add(input half_t a, input half_t b);
        half_t y;
        y = '0;
        for (int w = 0; w < NB; w++)
            y[w*B +: B] = a[w*B +: B] + b[w*B +: B];
        return y;
    endfunction

    function automatic half_t sea_sbox(input half_t x);
        half_t y;
        logic [2:0] s;
        y = '0;
        for (int g = 0; g < NG; g++) begin
            for (int j = 0; j < B; j++) begin
                s = sea_sbox3({x[(3*g+2)*B+j], x[(3*g+1)*B+j], x[3*g*B+j]});
                y[3*g*B+j]     = s[0];
                y[(3*g+1)*B+j] = s[1];
                y[(3*g+2)*B+j] = s[2];
            end
        end
        return y;
    endfunction

    function automatic half_t sea_rotbits(input half_t x);
        half_t y;
        logic [B-1:0] lo;
        logic [B-1:0] hi;
        y = x;
        for (int g = 0; g < NG; g++) begin
            lo = x[3*g*B +: B];
            hi = x[(3*g+2)*B +: B];
            y[3*g*B +: B]     = {lo[0], lo[B-1:1]};
            y[(3*g+2)*B +: B] = {hi[B-2:0], hi[B-1]};
        end
        return y;
    endfunction

    function automatic half_t sea_rotw(input half_t x);
        return {x[H-B-1:0], x[H-1:H-B]};
    endfunction

    function automatic half_t sea_rotw_inv(input half_t x);
        return {x[B-1:0], x[H-1:B]};
    endfunction

    function automatic half_t sea_const(input logic [CW-1:0] i);
        half_t y;
        y = '0;
        y[B-1:0] = B'(i);
        return y;
    endfunction

    function automatic half_t sea_f(input half_t x, input half_t k);
        return sea_rotbits(sea_sbox(sea_add(x, k)));
    endfunction

    // Forward round, or its exact inverse for decrypt.
    always_comb begin
        l_n  = '0;
        r_n  = '0;
        kl_n = '0;
        kr_n = '0;
        if (mode == MODE_ENC) begin
            l_n  = r;
            r_n  = sea_rotw(l) ^ sea_f(r, kr);
            kl_n = kr;
            kr_n = kl ^ sea_rotw(sea_f(kr, sea_const(idx)));
        end else begin
            kr_n = kl;
            kl_n = kr ^ sea_rotw(sea_f(kl, sea_const(idx)));
            r_n  = l;
            l_n  = sea_rotw_inv(r ^ sea_f(l, kl));
        end
    end

endmodule

// File: rtl/sea_iter_core.sv
// Iterative SEA(n,b) core: one round per clock,
// ready/valid on both sides, returns final key state.
module sea_iter_core
    import sea_iter_core_pkg::*;
#(
    parameter int N  = 96,
    parameter int B  = 8,
    parameter int NR = 3*N/4 + 2*(N/(2*B) + B/2)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_mode,
    input  logic [N/2-1:0] in_l,
    input  logic [N/2-1:0] in_r,
    input  logic [N/2-1:0] in_kl,
    input  logic [N/2-1:0] in_kr,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N/2-1:0] out_l,
    output logic [N/2-1:0] out_r,
    output logic [N/2-1:0] out_kl,
    output logic [N/2-1:0] out_kr,
    output logic           busy
);
    localparam int CW = (NR > 1) ? $clog2(NR) : 1;
    localparam logic [CW-1:0] LAST = CW'(NR - 1);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           mode_q;
    logic [N/2-1:0] l_q, r_q, kl_q, kr_q;
    logic [N/2-1:0] l_n, r_n, kl_n, kr_n;
    logic           last_round;

    assign last_round = mode_q ? (cnt == '0) : (cnt == LAST);

    sea_round #(.N(N), .B(B), .CW(CW)) u_round (
        .mode (mode_q),
        .l    (l_q),
        .r    (r_q),
        .kl   (kl_q),
        .kr   (kr_q),
        .idx  (cnt),
        .l_n  (l_n),
        .r_n  (r_n),
        .kl_n (kl_n),
        .kr_n (kr_n)
    );

    assign out_l  = l_q;
    assign out_r  = r_q;
    assign out_kl = kl_q;
    assign out_kr = kr_q;

    // Control FSM with registered handshake flags and the round state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mode_q    <= 1'b0;
            l_q       <= '0;
            r_q       <= '0;
            kl_q      <= '0;
            kr_q      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        mode_q   <= in_mode;
                        l_q      <= in_l;
                        r_q      <= in_r;
                        kl_q     <= in_kl;
                        kr_q     <= in_kr;
                        cnt      <= in_mode ? LAST : '0;
                        state    <= ST_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    l_q  <= l_n;
                    r_q  <= r_n;
                    kl_q <= kl_n;
                    kr_q <= kr_n;
                    if (last_round) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end else if (mode_q) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
